// File: rtl/mem_xfer_ctrl.sv
// mem_xfer_ctrl
// Control sequencer for a single CPU memory transfer through the MAR/MDR pair.
// A read or write request from the control unit is turned into the ordered
// sequence of MAR load, MDR load/mux select, MDR bus drive and memory strobes.
// The block then waits for the memory ready handshake, with a bounded timeout.
// The block holds no datapath. It only produces control strobes.
//
// Parameters:
//   TIMEOUT    maximum cycles spent in a wait state before aborting (1..255)
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   clear      synchronous active-high reset
//   rd_req     read request, sampled only in IDLE
//   wr_req     write request, sampled only in IDLE
//   mem_ready  memory finished the current access, sampled only while waiting
//   mar_in     load MAR from the bus
//   mdr_in     load MDR (MDRin)
//   mdr_select MDR input mux: 1 = memory data in, 0 = bus
//   mdr_out    MDR drives the bus
//   mem_read   memory read strobe
//   mem_write  memory write strobe
//   busy       high in every state except IDLE
//   done       one-cycle pulse when a transfer completes
//   error      one-cycle pulse when a transfer is aborted on timeout

module mem_xfer_ctrl #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic clear,
   input  logic rd_req,
   input  logic wr_req,
   input  logic mem_ready,
   output logic mar_in,
   output logic mdr_in,
   output logic mdr_select,
   output logic mdr_out,
   output logic mem_read,
   output logic mem_write,
   output logic busy,
   output logic done,
   output logic error
);

   typedef enum logic [2:0] {
      IDLE,
      WR_DATA,
      ADDR,
      RD_WAIT,
      RD_CAP,
      WR_WAIT,
      DONE,
      ERR
   } state_t;

   // The last counter value a wait state may reach before it aborts.
   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

   state_t     state;
   logic       op_read;
   logic [7:0] wait_cnt;

   // Output order: mar_in, mdr_in, mdr_select, mdr_out, mem_read, mem_write, busy, done, error
   logic [8:0] outs;

   assign {mar_in, mdr_in, mdr_select, mdr_out, mem_read, mem_write, busy, done, error} = outs;

   // Output decode for the state being entered. It is loaded into the output
   // register together with the state, so the outputs always match the state
   // register and no input reaches an output combinationally.
   function automatic logic [8:0] decode(input state_t s, input logic rd_op);
      logic [8:0] o;
      o = '0;
      case (s)
         IDLE:    o = 9'b0_0_0_0_0_0_0_0_0;
         WR_DATA: o = 9'b0_1_0_0_0_0_1_0_0;
         ADDR:    o = 9'b1_0_0_0_0_0_1_0_0;
         RD_WAIT: o = 9'b0_0_1_0_1_0_1_0_0;
         RD_CAP:  o = 9'b0_1_1_0_1_0_1_0_0;
         WR_WAIT: o = 9'b0_0_0_0_0_1_1_0_0;
         DONE:    o = {3'b000, rd_op, 5'b00110};
         ERR:     o = 9'b0_0_0_0_0_0_1_0_1;
         default: o = '0;
      endcase
      return o;
   endfunction

   // Sequencer. A read request wins over a simultaneous write request.
   // In a wait state, mem_ready is tested before the timeout, so a ready on
   // the last allowed cycle still counts as success. The counter therefore
   // covers exactly TIMEOUT wait cycles (0 .. TIMEOUT-1) before ERR.
   always_ff @(posedge clk) begin
      if (clear) begin
         state    <= IDLE;
         op_read  <= 1'b1;
         wait_cnt <= '0;
         outs     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (rd_req) begin
                  state   <= ADDR;
                  op_read <= 1'b1;
                  outs    <= decode(ADDR, 1'b1);
               end else if (wr_req) begin
                  state   <= WR_DATA;
                  op_read <= 1'b0;
                  outs    <= decode(WR_DATA, 1'b0);
               end
            end
            WR_DATA: begin
               state <= ADDR;
               outs  <= decode(ADDR, op_read);
            end
            ADDR: begin
               wait_cnt <= '0;
               if (op_read) begin
                  state <= RD_WAIT;
                  outs  <= decode(RD_WAIT, op_read);
               end else begin
                  state <= WR_WAIT;
                  outs  <= decode(WR_WAIT, op_read);
               end
            end
            RD_WAIT: begin
               if (mem_ready) begin
                  state <= RD_CAP;
                  outs  <= decode(RD_CAP, op_read);
               end else if (wait_cnt == LAST_CNT) begin
                  state <= ERR;
                  outs  <= decode(ERR, op_read);
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            RD_CAP: begin
               state <= DONE;
               outs  <= decode(DONE, op_read);
            end
            WR_WAIT: begin
               if (mem_ready) begin
                  state <= DONE;
                  outs  <= decode(DONE, op_read);
               end else if (wait_cnt == LAST_CNT) begin
                  state <= ERR;
                  outs  <= decode(ERR, op_read);
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            DONE, ERR: begin
               state <= IDLE;
               outs  <= decode(IDLE, op_read);
            end
            default: begin
               state <= IDLE;
               outs  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// tb_mem_xfer_ctrl
// Scoreboard bench for mem_xfer_ctrl. Two instances are used: dut_a with the
// default TIMEOUT of 15 and dut_b with TIMEOUT of 4.
// The stimulus process drives each cycle's inputs on the falling edge. It
// then queues the hand-written output vector expected after the next rising
// edge. A monitor pops one entry per cycle, just after the rising edge, and
// compares it. Small MAR/MDR register models hang off dut_a's strobes, so
// the captured address and data can also be checked.

module tb_mem_xfer_ctrl;

   // Expected vectors: mar_in, mdr_in, mdr_select, mdr_out, mem_read, mem_write, busy, done, error
   localparam logic [8:0] O_IDLE  = 9'b0_0_0_0_0_0_0_0_0;
   localparam logic [8:0] O_WRD   = 9'b0_1_0_0_0_0_1_0_0;
   localparam logic [8:0] O_ADDR  = 9'b1_0_0_0_0_0_1_0_0;
   localparam logic [8:0] O_RDW   = 9'b0_0_1_0_1_0_1_0_0;
   localparam logic [8:0] O_RDC   = 9'b0_1_1_0_1_0_1_0_0;
   localparam logic [8:0] O_WRW   = 9'b0_0_0_0_0_1_1_0_0;
   localparam logic [8:0] O_DONER = 9'b0_0_0_1_0_0_1_1_0;
   localparam logic [8:0] O_DONEW = 9'b0_0_0_0_0_0_1_1_0;
   localparam logic [8:0] O_ERR   = 9'b0_0_0_0_0_0_1_0_1;
   localparam logic [31:0] MDATAIN = 32'hDEADBEEF;

   typedef struct {
      logic [8:0]  exp_a;
      logic [8:0]  exp_b;
      logic        chk_regs;
      logic [31:0] mdr_exp;
      logic [31:0] mar_exp;
      int          tid;
      int          step;
   } entry_t;

   logic clk = 1'b0;
   logic clear = 1'b1;
   logic rd_a = 1'b0, wr_a = 1'b0, rdy_a = 1'b0;
   logic rd_b = 1'b0, wr_b = 1'b0, rdy_b = 1'b0;
   logic [31:0] bus = '0;

   logic mar_in_a, mdr_in_a, mdr_select_a, mdr_out_a, mem_read_a, mem_write_a, busy_a, done_a, error_a;
   logic mar_in_b, mdr_in_b, mdr_select_b, mdr_out_b, mem_read_b, mem_write_b, busy_b, done_b, error_b;
   logic [8:0] outs_a, outs_b;

   logic [31:0] mdr_a = '0;
   logic [31:0] mar_a = '0;

   entry_t sb_q[$];
   entry_t mon_e;
   int compared = 0;
   int mismatched = 0;
   int test_id = 0;
   int step_no = 0;
   logic pend_chk = 1'b0;
   logic [31:0] pend_mdr = '0;
   logic [31:0] pend_mar = '0;

   always #5 clk = ~clk;

   mem_xfer_ctrl dut_a (
      .clk(clk), .clear(clear), .rd_req(rd_a), .wr_req(wr_a), .mem_ready(rdy_a),
      .mar_in(mar_in_a), .mdr_in(mdr_in_a), .mdr_select(mdr_select_a), .mdr_out(mdr_out_a),
      .mem_read(mem_read_a), .mem_write(mem_write_a), .busy(busy_a), .done(done_a), .error(error_a)
   );

   mem_xfer_ctrl #(.TIMEOUT(4)) dut_b (
      .clk(clk), .clear(clear), .rd_req(rd_b), .wr_req(wr_b), .mem_ready(rdy_b),
      .mar_in(mar_in_b), .mdr_in(mdr_in_b), .mdr_select(mdr_select_b), .mdr_out(mdr_out_b),
      .mem_read(mem_read_b), .mem_write(mem_write_b), .busy(busy_b), .done(done_b), .error(error_b)
   );

   assign outs_a = {mar_in_a, mdr_in_a, mdr_select_a, mdr_out_a, mem_read_a, mem_write_a, busy_a, done_a, error_a};
   assign outs_b = {mar_in_b, mdr_in_b, mdr_select_b, mdr_out_b, mem_read_b, mem_write_b, busy_b, done_b, error_b};

   // External MAR/MDR registers driven by dut_a's strobes.
   always @(posedge clk) begin
      if (mdr_in_a) mdr_a <= mdr_select_a ? MDATAIN : bus;
      if (mar_in_a) mar_a <= bus;
   end

   task automatic checkOutput(input string name, input int tid, input int step,
                              input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s test %0d step %0d: actual %h required %h", name, tid, step, actual, expected);
      end
   endtask

   // Queue the register check to attach to the next applyStimulus entry.
   task automatic arm_reg_check(input logic [31:0] mdr_e, input logic [31:0] mar_e);
      pend_chk = 1'b1;
      pend_mdr = mdr_e;
      pend_mar = mar_e;
   endtask

   // Drive one cycle of inputs into the selected instance and queue the
   // expected outputs after the next rising edge. The other instance stays idle.
   task automatic applyStimulus(input logic sel_b, input logic clr, input logic rd, input logic wr,
                                input logic rdy, input logic [31:0] b, input logic [8:0] exp);
      entry_t e;
      @(negedge clk);
      clear = clr;
      bus   = b;
      rd_a  = sel_b ? 1'b0 : rd;
      wr_a  = sel_b ? 1'b0 : wr;
      rdy_a = sel_b ? 1'b0 : rdy;
      rd_b  = sel_b ? rd : 1'b0;
      wr_b  = sel_b ? wr : 1'b0;
      rdy_b = sel_b ? rdy : 1'b0;
      step_no++;
      e.exp_a    = sel_b ? O_IDLE : exp;
      e.exp_b    = sel_b ? exp : O_IDLE;
      e.chk_regs = pend_chk;
      e.mdr_exp  = pend_mdr;
      e.mar_exp  = pend_mar;
      e.tid      = test_id;
      e.step     = step_no;
      sb_q.push_back(e);
      pend_chk = 1'b0;
   endtask

   // Monitor: one scoreboard entry per cycle, sampled just after the rising edge.
   always @(posedge clk) begin
      #1;
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         checkOutput("outs_a", mon_e.tid, mon_e.step, 32'(outs_a), 32'(mon_e.exp_a));
         checkOutput("outs_b", mon_e.tid, mon_e.step, 32'(outs_b), 32'(mon_e.exp_b));
         if (mon_e.chk_regs) begin
            checkOutput("mdr", mon_e.tid, mon_e.step, mdr_a, mon_e.mdr_exp);
            checkOutput("mar", mon_e.tid, mon_e.step, mar_a, mon_e.mar_exp);
         end
      end
   end

   initial begin
      // Reset with rd_req held, then read with ready from the first wait cycle.
      test_id = 1; step_no = 0;
      applyStimulus(0, 1, 1, 0, 0, 32'h0, O_IDLE);
      applyStimulus(0, 1, 1, 0, 0, 32'h0, O_IDLE);
      applyStimulus(0, 0, 1, 0, 1, 32'h100, O_ADDR);
      applyStimulus(0, 0, 0, 0, 1, 32'h100, O_RDW);
      applyStimulus(0, 0, 0, 0, 1, 32'h0, O_RDC);
      arm_reg_check(32'hDEADBEEF, 32'h100);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, O_DONER);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, O_IDLE);

      // Write with ready on the fourth wait cycle and a wr_req pulse while busy.
      test_id = 2; step_no = 0;
      applyStimulus(0, 0, 0, 1, 0, 32'h0, O_WRD);
      applyStimulus(0, 0, 0, 0, 0, 32'h12345678, O_ADDR);
      applyStimulus(0, 0, 0, 0, 0, 32'h40, O_WRW);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, O_WRW);
      applyStimulus(0, 0, 0, 1, 0, 32'h0, O_WRW);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, O_WRW);
      arm_reg_check(32'h12345678, 32'h40);
      applyStimulus(0, 0, 0, 0, 1, 32'h0, O_DONEW);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, O_IDLE);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, O_IDLE);

      // Read timeout: 15 cycles of mem_read, one ERR cycle, MDR untouched.
      test_id = 3; step_no = 0;
      applyStimulus(0, 0, 1, 0, 0, 32'h200, O_ADDR);
      applyStimulus(0, 0, 0, 0, 0, 32'h200, O_RDW);
      for (int i = 0; i < 14; i++) applyStimulus(0, 0, 0, 0, 0, 32'h0, O_RDW);
      arm_reg_check(32'h12345678, 32'h200);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, O_ERR);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, O_IDLE);

      // Read and write requested together: read wins, no WR_DATA cycle.
      test_id = 4; step_no = 0;
      applyStimulus(0, 0, 1, 1, 0, 32'h300, O_ADDR);
      applyStimulus(0, 0, 0, 1, 0, 32'h300, O_RDW);
      applyStimulus(0, 0, 0, 0, 1, 32'h0, O_RDC);
      arm_reg_check(32'hDEADBEEF, 32'h300);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, O_DONER);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, O_IDLE);

      // Clear in RD_WAIT, then a fresh read that is ready on its 15th wait cycle.
      test_id = 5; step_no = 0;
      applyStimulus(0, 0, 1, 0, 0, 32'h400, O_ADDR);
      applyStimulus(0, 0, 0, 0, 0, 32'h400, O_RDW);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, O_RDW);
      applyStimulus(0, 1, 0, 0, 0, 32'h0, O_IDLE);
      applyStimulus(0, 0, 1, 0, 0, 32'h500, O_ADDR);
      applyStimulus(0, 0, 0, 0, 0, 32'h500, O_RDW);
      for (int i = 0; i < 14; i++) applyStimulus(0, 0, 0, 0, 0, 32'h0, O_RDW);
      applyStimulus(0, 0, 0, 0, 1, 32'h0, O_RDC);
      arm_reg_check(32'hDEADBEEF, 32'h500);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, O_DONER);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, O_IDLE);

      // TIMEOUT=4: ready on the 4th wait cycle succeeds.
      test_id = 6; step_no = 0;
      applyStimulus(1, 0, 1, 0, 0, 32'h0, O_ADDR);
      applyStimulus(1, 0, 0, 0, 0, 32'h0, O_RDW);
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 32'h0, O_RDW);
      applyStimulus(1, 0, 0, 0, 1, 32'h0, O_RDC);
      applyStimulus(1, 0, 0, 0, 0, 32'h0, O_DONER);
      applyStimulus(1, 0, 0, 0, 0, 32'h0, O_IDLE);

      // TIMEOUT=4: ready never comes, so ERR follows the 4th wait cycle.
      test_id = 7; step_no = 0;
      applyStimulus(1, 0, 1, 0, 0, 32'h0, O_ADDR);
      applyStimulus(1, 0, 0, 0, 0, 32'h0, O_RDW);
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 32'h0, O_RDW);
      applyStimulus(1, 0, 0, 0, 0, 32'h0, O_ERR);
      applyStimulus(1, 0, 0, 0, 0, 32'h0, O_IDLE);

      // Let the monitor drain the scoreboard, with a bounded number of cycles.
      for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
      checkOutput("drain", test_id, step_no, 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mem_xfer_ctrl.md
# mem_xfer_ctrl

Sequencer for one CPU memory transfer through the MAR/MDR pair. Accepts a read or write request from the control unit and drives MAR load, MDR load/mux select, MDR bus drive and the memory read/write strobes in the right order. Waits on a memory ready handshake with a bounded timeout. Sits between the control unit and the MAR, MDR and memory port; it contains no datapath, only control.

## Interface
- TIMEOUT, default 15: maximum cycles spent in a wait state before abort; legal range 1..255.
- clk  in  1  system clock; all state changes on the rising edge.
- clear  in  1  synchronous, active-high reset.
- rd_req  in  1  read request; sampled only in IDLE.
- wr_req  in  1  write request; sampled only in IDLE.
- mem_ready  in  1  memory has completed the current access; sampled only in RD_WAIT/WR_WAIT.
- mar_in  out  1  load MAR from the bus this cycle.
- mdr_in  out  1  load MDR this cycle; drives the MDR's MDRin.
- mdr_select  out  1  MDR input mux select: 1 = memory data in, 0 = bus.
- mdr_out  out  1  MDR drives the bus this cycle.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: transfer completed.
- error  out  1  one-cycle pulse: transfer aborted on timeout.

## Operation
- States: IDLE, WR_DATA, ADDR, RD_WAIT, RD_CAP, WR_WAIT, DONE, ERR.
- A 1-bit op register records read/write, and an 8-bit wait counter.
- All outputs are decoded from the state and op registers only. There is no combinational path from any input to any output.
- IDLE: all outputs 0.
  - rd_req=1 → ADDR, op=read.
  - Else wr_req=1 → WR_DATA, op=write.
  - Read wins when both are high.
- WR_DATA: mdr_in=1, mdr_select=0; MDR captures write data from the bus. → ADDR.
- ADDR: mar_in=1; MAR captures the address from the bus. Wait counter cleared to 0. → RD_WAIT if op=read, else WR_WAIT.
- RD_WAIT: mem_read=1, mdr_select=1.
  - mem_ready=1 → RD_CAP.
  - Else if counter==TIMEOUT-1 → ERR.
  - Else counter+1.
- RD_CAP: mem_read=1, mdr_select=1, mdr_in=1; MDR captures Mdatain. → DONE.
- WR_WAIT: mem_write=1, mdr_select=0.
  - mem_ready=1 → DONE.
  - Else if counter==TIMEOUT-1 → ERR.
  - Else counter+1.
- DONE: done=1. mdr_out=1 if op=read, otherwise 0. → IDLE.
- ERR: error=1; all strobes 0; MDR is never loaded on an aborted read. → IDLE.
- mdr_select is 0 in every state not listed above.
- Requests arriving while busy=1 are ignored; they are not queued.
- mem_ready outside the wait states is ignored.
- mem_ready=1 on the cycle where the counter equals TIMEOUT-1 counts as success; it beats the timeout.
- done and error are never high together. Exactly one of them pulses per accepted request.

## Timing
- Reset: clear=1 at an edge → IDLE, counter=0, op=read. All outputs are 0 in the next cycle, regardless of the current state, including mid-transfer. A request held during clear is sampled on the first IDLE cycle after clear falls.
- Read latency, with request sampled at edge 0 and ready on the first wait cycle: ADDR in cycle 1, RD_WAIT cycle 2, RD_CAP cycle 3, DONE cycle 4. Each extra wait cycle adds 1.
- Write latency: WR_DATA in cycle 1, ADDR cycle 2, WR_WAIT cycle 3, DONE cycle 4 with first-cycle ready.
- Timeout: exactly TIMEOUT cycles are spent in a wait state, then one ERR cycle.
- Back-to-back: a new request is accepted in the IDLE cycle following DONE/ERR. The minimum request-to-request spacing is 5 cycles.
- The requester must present write data on the bus in the WR_DATA cycle and the address in the ADDR cycle.

## Test plan
- Read, mem_ready high from start: rd_req pulse → mar_in in cycle 1, mem_read in cycles 2–3, mdr_in+mdr_select in cycle 3, done+mdr_out in cycle 4, busy cycles 1–4. MDR holds 0xDEADBEEF from Mdatain.
- Write, mem_ready after 3 wait cycles: bus 0x12345678 then 0x00000040 → mdr_in with select=0 in cycle 1, mar_in in cycle 2, mem_write in cycles 3–6, done in cycle 7. mdr_out stays 0 throughout.
- Timeout, TIMEOUT=15, mem_ready stuck low on a read → 15 cycles of mem_read, error for 1 cycle, done never asserted, mdr_in never asserted, MDR unchanged.
- Ready on the last allowed cycle, TIMEOUT=4, ready in the 4th wait cycle → RD_CAP then done; no error.
- rd_req and wr_req high together in IDLE → read sequence, with no WR_DATA cycle. wr_req pulsed during busy → ignored, no second transfer.
- clear asserted in RD_WAIT → all outputs 0 next cycle, busy=0. A following rd_req starts a fresh transfer with full timeout.
